// File: rtl/mem_burst_responder_if.sv
// Cache-to-memory 4-beat burst bus between the data cache (master) and mem_burst_responder (slave).
interface mem_burst_responder_if #(
    parameter int unsigned PHYSICAL_ADDR_BITS = 32,
    parameter int unsigned XLEN               = 32
);
    logic                          mr_in;
    logic                          mw_in;
    logic [PHYSICAL_ADDR_BITS-1:0] maddr_in;
    logic [XLEN-1:0]               mword_in;
    logic [XLEN-1:0]               mword_out;
    logic                          mready_out;
    logic                          busy_out;
    logic                          proto_err_out;

    modport master (
        output mr_in, mw_in, maddr_in, mword_in,
        input  mword_out, mready_out, busy_out, proto_err_out
    );

    modport slave (
        input  mr_in, mw_in, maddr_in, mword_in,
        output mword_out, mready_out, busy_out, proto_err_out
    );
endinterface

// File: rtl/mem_burst_responder.sv
// Block-RAM stand-in for DRAM behind the data cache: 4-beat read/write bursts with programmable latency.
// Optional macro MEM_BURST_PROTO_CHECK_EN builds the sticky protocol-error checker.
module mem_burst_responder #(
    parameter int unsigned MEM_WORD_BITS      = 14,
    parameter int unsigned RD_LATENCY         = 4,
    parameter int unsigned WR_LATENCY         = 2,
    parameter int unsigned PHYSICAL_ADDR_BITS = 32,
    parameter int unsigned XLEN               = 32
) (
    input logic                  clk,
    input logic                  rst,
    mem_burst_responder_if.slave bus
);
    localparam int unsigned LINE_W      = MEM_WORD_BITS - 2;
    localparam int unsigned DEPTH       = 1 << MEM_WORD_BITS;
    localparam int unsigned MAX_LAT     = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W       = $clog2(MAX_LAT + 1);
    localparam int unsigned RD_CNT_INIT = RD_LATENCY - 2;
    localparam int unsigned WR_CNT_INIT = (WR_LATENCY > 0) ? WR_LATENCY - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_WR_WAIT,
        S_WR_ACK
    } state_e;

    state_e                   state_q;
    logic [LINE_W-1:0]        line_q;
    logic [1:0]               beat_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [XLEN-1:0]          mword_q;
    logic                     mready_q;
    logic                     busy_q;
    logic [XLEN-1:0]          ram_q [DEPTH];

    logic [LINE_W-1:0]        cmd_line_c;
    logic                     ram_we_c;
    logic [MEM_WORD_BITS-1:0] ram_waddr_c;
    logic [MEM_WORD_BITS-1:0] ram_raddr_c;
    logic                     unused_c;

    assign cmd_line_c = bus.maddr_in[MEM_WORD_BITS+1:4];
    assign unused_c   = ^bus.maddr_in;

    // Beat 0 of a write lands in the command cycle; beats 1..3 follow in WR_BURST.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = {line_q, beat_q};
        ram_raddr_c = (state_q == S_RD_WAIT) ? {line_q, 2'b00} : {line_q, beat_q + 2'd1};
        if (!rst) begin
            if (state_q == S_IDLE && bus.mw_in) begin
                ram_we_c    = 1'b1;
                ram_waddr_c = {cmd_line_c, 2'b00};
            end else if (state_q == S_WR_BURST) begin
                ram_we_c = 1'b1;
            end
        end
    end

    // Backing store is never reset so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram_q[ram_waddr_c] <= bus.mword_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            beat_q   <= '0;
            cnt_q    <= '0;
            mword_q  <= '0;
            mready_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mready_q <= 1'b0;
            mword_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mw_in || bus.mr_in) begin
                        line_q <= cmd_line_c;
                        busy_q <= 1'b1;
                    end
                    if (bus.mw_in) begin
                        state_q <= S_WR_BURST;
                        beat_q  <= 2'd1;
                    end else if (bus.mr_in) begin
                        state_q <= S_RD_WAIT;
                        cnt_q   <= CNT_W'(RD_CNT_INIT);
                    end
                end
                // Last wait cycle issues the synchronous read of beat 0.
                S_RD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_RD_BURST;
                        beat_q   <= 2'd0;
                        mready_q <= 1'b1;
                        mword_q  <= ram_q[ram_raddr_c];
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RD_BURST: begin
                    if (beat_q == 2'd3) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        beat_q  <= beat_q + 2'd1;
                        mword_q <= ram_q[ram_raddr_c];
                    end
                end
                S_WR_BURST: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        if (WR_LATENCY == 0) begin
                            state_q  <= S_WR_ACK;
                            mready_q <= 1'b1;
                        end else begin
                            state_q <= S_WR_WAIT;
                            cnt_q   <= CNT_W'(WR_CNT_INIT);
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_WR_ACK;
                        mready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WR_ACK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mword_out  = mword_q;
    assign bus.mready_out = mready_q;
    assign bus.busy_out   = busy_q;

`ifdef MEM_BURST_PROTO_CHECK_EN
    logic proto_err_q;
    logic cmd_c;

    assign cmd_c = bus.mr_in | bus.mw_in;

    // Sticky until reset: command while busy, read/write collision, or misaligned burst address.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (cmd_c && (busy_q || (bus.mr_in && bus.mw_in) || (bus.maddr_in[3:2] != 2'b00))) begin
            proto_err_q <= 1'b1;
        end
    end

    assign bus.proto_err_out = proto_err_q;
`else
    assign bus.proto_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench for mem_burst_responder: default-latency and minimum-latency/small-RAM instances share one stimulus stream.
module tb_mem_burst_responder;
    localparam int unsigned MB0 = 14, RL0 = 4, WL0 = 2;
    localparam int unsigned MB1 = 6,  RL1 = 2, WL1 = 0;
    localparam int          INF = 32'h7fffffff;
`ifdef MEM_BURST_PROTO_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          rdy;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr, mw;
    logic [31:0] maddr, mword;

    always #5 clk = ~clk;

    mem_burst_responder_if bus0 ();
    mem_burst_responder_if bus1 ();

    assign bus0.mr_in = mr;    assign bus1.mr_in = mr;
    assign bus0.mw_in = mw;    assign bus1.mw_in = mw;
    assign bus0.maddr_in = maddr; assign bus1.maddr_in = maddr;
    assign bus0.mword_in = mword; assign bus1.mword_in = mword;

    mem_burst_responder #(.MEM_WORD_BITS(MB0), .RD_LATENCY(RL0), .WR_LATENCY(WL0),
                          .PHYSICAL_ADDR_BITS(32), .XLEN(32))
        u0 (.clk(clk), .rst(rst), .bus(bus0));

    mem_burst_responder #(.MEM_WORD_BITS(MB1), .RD_LATENCY(RL1), .WR_LATENCY(WL1),
                          .PHYSICAL_ADDR_BITS(32), .XLEN(32))
        u1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model state, per instance
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem [int];
    int          free_c [2];
    int          acc_c [2];
    int          plo [2];
    int          phi [2];

    int cyc    = 0;
    bit mon_en = 1'b0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int word_of(input int i, input logic [31:0] a);
        int unsigned mb;
        mb = (i == 0) ? MB0 : MB1;
        return int'(((a >> 4) << 2) & ((32'd1 << mb) - 32'd1));
    endfunction

    function automatic int key_of(input int i, input int w);
        return i * 65536 + w;
    endfunction

    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Command seen in cycle c: decide acceptance per instance and schedule its responses.
    task automatic model_cmd(input int c, input bit r, input bit w, input logic [31:0] a,
                             input logic [3:0][31:0] d);
        for (int i = 0; i < 2; i++) begin
            bit   idle;
            int   wd;
            int   rl;
            int   wl;
            exp_t e;
            idle = (c >= free_c[i]);
            wd   = word_of(i, a);
            rl   = (i == 0) ? int'(RL0) : int'(RL1);
            wl   = (i == 0) ? int'(WL0) : int'(WL1);
            if (PCHK && (r || w) && (!idle || (r && w) || (a[3:2] != 2'b00))
                && !(plo[i] <= c + 1 && c + 1 < phi[i])) begin
                plo[i] = c + 1;
                phi[i] = INF;
            end
            if (idle && w) begin
                for (int k = 0; k < 4; k++) mem[key_of(i, wd + k)] = d[k];
                e.cyc = c + 4 + wl; e.rdy = 1'b1; e.data = 32'd0;
                push(i, e);
                acc_c[i]  = c;
                free_c[i] = c + 5 + wl;
            end else if (idle && r) begin
                for (int k = 0; k < 4; k++) begin
                    e.cyc  = c + rl + k;
                    e.rdy  = (k == 0);
                    e.data = mem.exists(key_of(i, wd + k)) ? mem[key_of(i, wd + k)] : 32'hxxxxxxxx;
                    push(i, e);
                end
                acc_c[i]  = c;
                free_c[i] = c + rl + 4;
            end
        end
    endtask

    // Reset sampled at the end of cycle r: everything scheduled later is abandoned.
    task automatic model_reset(input int r);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                while (q0.size() > 0 && q0[q0.size()-1].cyc > r) void'(q0.pop_back());
            end else begin
                while (q1.size() > 0 && q1[q1.size()-1].cyc > r) void'(q1.pop_back());
            end
            free_c[i] = r + 1;
            acc_c[i]  = r;
            if (plo[i] <= r && r + 1 < phi[i]) phi[i] = r + 1;
        end
    endtask

    task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic [31:0] wd,
                              input logic bsy, input logic perr);
        exp_t e;
        bit   due;
        due = 1'b0;
        if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); due = 1'b1; end
        if (i == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); due = 1'b1; end
        if (due) begin
            cmp("mready", i, 32'(rdy), 32'(e.rdy));
            cmp("mword",  i, wd, e.data);
        end else begin
            cmp("mready_idle", i, 32'(rdy), 32'd0);
            cmp("mword_idle",  i, wd, 32'd0);
        end
        cmp("busy",      i, 32'(bsy),  32'(acc_c[i] < cyc && cyc < free_c[i]));
        cmp("proto_err", i, 32'(perr), 32'(plo[i] <= cyc && cyc < phi[i]));
    endtask

    // Monitor: compares both instances every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, bus0.mready_out, bus0.mword_out, bus0.busy_out, bus0.proto_err_out);
            check_inst(1, bus1.mready_out, bus1.mword_out, bus1.busy_out, bus1.proto_err_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit r, input bit w, input logic [31:0] a,
                         input logic [3:0][31:0] d, input bit spur);
        int c;
        c = cyc;
        mr = r; mw = w; maddr = a; mword = d[0];
        model_cmd(c, r, w, a, d);
        for (int k = 1; k < 4; k++) begin
            tick();
            mr = 1'b0; mw = 1'b0; maddr = $urandom; mword = d[k];
            if (spur && $urandom_range(3) == 0) begin
                mr = 1'b1;
                model_cmd(cyc, 1'b1, 1'b0, maddr, '0);
            end
        end
        tick();
        mr = 1'b0; mw = 1'b0; mword = $urandom;
    endtask

    task automatic wait_free(input int gap, input bit spur);
        int tgt;
        tgt = ((free_c[0] > free_c[1]) ? free_c[0] : free_c[1]) + gap;
        while (cyc < tgt) begin
            if (spur && cyc < free_c[0] && cyc < free_c[1] && $urandom_range(5) == 0) begin
                mr    = 1'($urandom_range(1));
                mw    = !mr || ($urandom_range(1) == 1);
                maddr = $urandom;
                model_cmd(cyc, mr, mw, maddr, '0);
            end
            tick();
            mr = 1'b0; mw = 1'b0;
        end
    endtask

    task automatic reset_read(input logic [31:0] a, input int beat);
        int c;
        c = cyc;
        issue(1'b1, 1'b0, a, '0, 1'b0);
        while (cyc < c + int'(RL0) + beat) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset(cyc - 1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {(($urandom_range(3) == 0) ? 16'($urandom) : 16'h0), 4'h0, 8'($urandom), 2'b00, 2'($urandom)};
        if ($urandom_range(7) == 0) a[3:2] = 2'($urandom);
        return a;
    endfunction

    function automatic logic [3:0][31:0] rand_data();
        logic [3:0][31:0] d;
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        return d;
    endfunction

    initial begin
        logic [3:0][31:0] d;
        int               sel;
        rst = 1'b1; mr = 1'b0; mw = 1'b0; maddr = '0; mword = '0;
        for (int i = 0; i < 2; i++) begin
            free_c[i] = 0; acc_c[i] = -1; plo[i] = INF; phi[i] = INF;
        end
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // Fill every line either instance can reach from the stimulus address range
        for (int l = 0; l < 256; l++) begin
            issue(1'b0, 1'b1, 32'(l << 4), rand_data(), 1'b0);
            wait_free(0, 1'b0);
        end

        // Write then read back line 0x100, back to back
        d = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        issue(1'b0, 1'b1, 32'h100, d, 1'b0);
        wait_free(0, 1'b0);
        issue(1'b1, 1'b0, 32'h100, '0, 1'b0);
        wait_free(0, 1'b0);
        issue(1'b0, 1'b1, 32'h200, rand_data(), 1'b0);
        wait_free(0, 1'b0);

        // Aliasing: 0x1F0 wraps onto word 60 in the small RAM
        issue(1'b0, 1'b1, 32'h0F0, rand_data(), 1'b0);
        wait_free(0, 1'b0);
        issue(1'b1, 1'b0, 32'h1F0, '0, 1'b0);
        wait_free(0, 1'b0);

        // Read/write collision and commands during a write burst
        issue(1'b1, 1'b1, 32'h40, rand_data(), 1'b1);
        wait_free(0, 1'b1);
        issue(1'b1, 1'b0, 32'h40, '0, 1'b0);
        wait_free(0, 1'b0);

        // Reset in read beat 1, then the data must still be there
        reset_read(32'h100, 1);
        issue(1'b1, 1'b0, 32'h100, '0, 1'b0);
        wait_free(0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(99);
            if (sel < 45)      issue(1'b1, 1'b0, rand_addr(), '0, 1'b1);
            else if (sel < 90) issue(1'b0, 1'b1, rand_addr(), rand_data(), 1'b1);
            else if (sel < 96) issue(1'b1, 1'b1, rand_addr(), rand_data(), 1'b1);
            else begin
                wait_free(0, 1'b0);
                reset_read(rand_addr(), $urandom_range(3));
            end
            wait_free(($urandom_range(2) == 0) ? $urandom_range(3) : 0, 1'b1);
        end

        wait_free(2, 1'b0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
